// File: rtl/i2c_slave.sv
// 7-bit-address I2C target: oversampled START/Sr/STOP detection, write bytes to rx_byte,
// 16-bit word served on reads. Optional input glitch filter: I2C_SLAVE_FILTER_EN.
module i2c_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'h48
) (
  input  logic        clk,
  input  logic        rst,
  inout  wire         sda,
  input  logic        scl,
  input  logic [15:0] tx_data,
  output logic [7:0]  rx_byte,
  output logic        rx_valid,
  output logic        rw,
  output logic        busy
);

  // state     | meaning
  // IDLE      | bus ignored until START
  // ADDR      | shifting 7 address bits + rw
  // ADDR_ACK  | driving address ACK (ack_phase marks it is asserted)
  // RX_BYTE   | shifting a written data byte
  // RX_ACK    | driving data ACK
  // TX_BYTE   | presenting read data bits
  // TX_ACK    | sampling master ACK/NACK
  // WAIT_STOP | not addressed, wait for START/Sr or STOP
  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_RX_BYTE,
    S_RX_ACK,
    S_TX_BYTE,
    S_TX_ACK,
    S_WAIT_STOP
  } state_t;

  logic r_scl_s1, r_scl_s2, r_sda_s1, r_sda_s2;
  logic r_scl_prev, r_sda_prev;
  logic w_scl, w_sda;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_scl_s1 <= 1'b1;
      r_scl_s2 <= 1'b1;
      r_sda_s1 <= 1'b1;
      r_sda_s2 <= 1'b1;
    end else begin
      r_scl_s1 <= scl;
      r_scl_s2 <= r_scl_s1;
      r_sda_s1 <= sda;
      r_sda_s2 <= r_sda_s1;
    end
  end

`ifdef I2C_SLAVE_FILTER_EN
  logic [1:0] r_scl_hist, r_sda_hist;
  logic       r_scl_flt, r_sda_flt;

  // 3-sample majority rejects single-clk pulses; adds two clk of latency
  always_ff @(posedge clk) begin
    if (rst) begin
      r_scl_hist <= 2'b11;
      r_sda_hist <= 2'b11;
      r_scl_flt  <= 1'b1;
      r_sda_flt  <= 1'b1;
    end else begin
      r_scl_hist <= {r_scl_hist[0], r_scl_s2};
      r_sda_hist <= {r_sda_hist[0], r_sda_s2};
      r_scl_flt  <= (r_scl_s2 & r_scl_hist[0]) | (r_scl_s2 & r_scl_hist[1]) |
                    (r_scl_hist[0] & r_scl_hist[1]);
      r_sda_flt  <= (r_sda_s2 & r_sda_hist[0]) | (r_sda_s2 & r_sda_hist[1]) |
                    (r_sda_hist[0] & r_sda_hist[1]);
    end
  end

  assign w_scl = r_scl_flt;
  assign w_sda = r_sda_flt;
`else
  assign w_scl = r_scl_s2;
  assign w_sda = r_sda_s2;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_scl_prev <= 1'b1;
      r_sda_prev <= 1'b1;
    end else begin
      r_scl_prev <= w_scl;
      r_sda_prev <= w_sda;
    end
  end

  logic w_scl_rise, w_scl_fall, w_start, w_stop;
  assign w_scl_rise = w_scl & ~r_scl_prev;
  assign w_scl_fall = ~w_scl & r_scl_prev;
  assign w_start    = ~w_sda & r_sda_prev & w_scl;
  assign w_stop     = w_sda & ~r_sda_prev & w_scl;

  state_t      r_state, w_state_nx;
  logic [2:0]  r_bit_cnt, w_bit_cnt_nx;
  logic [6:0]  r_shift, w_shift_nx;
  logic [15:0] r_tx_shift, w_tx_shift_nx;
  logic        r_sda_low, w_sda_low_nx;
  logic [7:0]  r_rx_byte, w_rx_byte_nx;
  logic        r_rx_valid, w_rx_valid_nx;
  logic        r_rw, w_rw_nx;
  logic        r_busy, w_busy_nx;
  logic        r_ack_phase, w_ack_phase_nx;
  logic [7:0]  w_byte;

  assign w_byte = {r_shift, w_sda};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_bit_cnt   <= 3'd0;
      r_shift     <= 7'd0;
      r_tx_shift  <= 16'd0;
      r_sda_low   <= 1'b0;
      r_rx_byte   <= 8'h00;
      r_rx_valid  <= 1'b0;
      r_rw        <= 1'b0;
      r_busy      <= 1'b0;
      r_ack_phase <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_bit_cnt   <= w_bit_cnt_nx;
      r_shift     <= w_shift_nx;
      r_tx_shift  <= w_tx_shift_nx;
      r_sda_low   <= w_sda_low_nx;
      r_rx_byte   <= w_rx_byte_nx;
      r_rx_valid  <= w_rx_valid_nx;
      r_rw        <= w_rw_nx;
      r_busy      <= w_busy_nx;
      r_ack_phase <= w_ack_phase_nx;
    end
  end

  always_comb begin
    w_state_nx     = r_state;
    w_bit_cnt_nx   = r_bit_cnt;
    w_shift_nx     = r_shift;
    w_tx_shift_nx  = r_tx_shift;
    w_sda_low_nx   = r_sda_low;
    w_rx_byte_nx   = r_rx_byte;
    w_rx_valid_nx  = 1'b0;
    w_rw_nx        = r_rw;
    w_busy_nx      = r_busy;
    w_ack_phase_nx = r_ack_phase;

    if (w_stop) begin
      w_state_nx   = S_IDLE;
      w_sda_low_nx = 1'b0;
      w_busy_nx    = 1'b0;
      w_bit_cnt_nx = 3'd0;
    end else if (w_start) begin
      w_state_nx   = S_ADDR;
      w_bit_cnt_nx = 3'd7;
      w_sda_low_nx = 1'b0;
      w_busy_nx    = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_sda_low_nx = 1'b0;
        end

        S_ADDR: begin
          if (w_scl_rise) begin
            w_shift_nx = w_byte[6:0];
            if (r_bit_cnt == 3'd0) begin
              if (w_byte[7:1] == SLAVE_ADDR) begin
                w_rw_nx        = w_byte[0];
                w_busy_nx      = 1'b1;
                w_ack_phase_nx = 1'b0;
                w_state_nx     = S_ADDR_ACK;
                if (w_byte[0]) w_tx_shift_nx = tx_data;
              end else begin
                w_state_nx = S_WAIT_STOP;
              end
            end else begin
              w_bit_cnt_nx = r_bit_cnt - 3'd1;
            end
          end
        end

        S_ADDR_ACK: begin
          if (w_scl_fall) begin
            if (!r_ack_phase) begin
              w_sda_low_nx   = 1'b1;
              w_ack_phase_nx = 1'b1;
            end else begin
              w_bit_cnt_nx = 3'd7;
              if (r_rw) begin
                w_sda_low_nx  = ~r_tx_shift[15];
                w_tx_shift_nx = {r_tx_shift[14:0], 1'b1};
                w_state_nx    = S_TX_BYTE;
              end else begin
                w_sda_low_nx = 1'b0;
                w_state_nx   = S_RX_BYTE;
              end
            end
          end
        end

        S_RX_BYTE: begin
          if (w_scl_rise) begin
            w_shift_nx = w_byte[6:0];
            if (r_bit_cnt == 3'd0) begin
              w_rx_byte_nx   = w_byte;
              w_rx_valid_nx  = 1'b1;
              w_ack_phase_nx = 1'b0;
              w_state_nx     = S_RX_ACK;
            end else begin
              w_bit_cnt_nx = r_bit_cnt - 3'd1;
            end
          end
        end

        S_RX_ACK: begin
          if (w_scl_fall) begin
            if (!r_ack_phase) begin
              w_sda_low_nx   = 1'b1;
              w_ack_phase_nx = 1'b1;
            end else begin
              w_sda_low_nx = 1'b0;
              w_bit_cnt_nx = 3'd7;
              w_state_nx   = S_RX_BYTE;
            end
          end
        end

        // MSB was already placed on entry; each fall presents the next bit,
        // the fall after the LSB hands the line back for the master's ACK
        S_TX_BYTE: begin
          if (w_scl_fall) begin
            if (r_bit_cnt == 3'd0) begin
              w_sda_low_nx   = 1'b0;
              w_ack_phase_nx = 1'b0;
              w_state_nx     = S_TX_ACK;
            end else begin
              w_sda_low_nx  = ~r_tx_shift[15];
              w_tx_shift_nx = {r_tx_shift[14:0], 1'b1};
              w_bit_cnt_nx  = r_bit_cnt - 3'd1;
            end
          end
        end

        S_TX_ACK: begin
          if (w_scl_rise) begin
            if (w_sda) begin
              w_sda_low_nx = 1'b0;
              w_busy_nx    = 1'b0;
              w_state_nx   = S_WAIT_STOP;
            end else begin
              w_ack_phase_nx = 1'b1;
            end
          end else if (w_scl_fall && r_ack_phase) begin
            w_sda_low_nx  = ~r_tx_shift[15];
            w_tx_shift_nx = {r_tx_shift[14:0], 1'b1};
            w_bit_cnt_nx  = 3'd7;
            w_state_nx    = S_TX_BYTE;
          end
        end

        S_WAIT_STOP: begin
          w_sda_low_nx = 1'b0;
        end

        default: begin
          w_state_nx   = S_IDLE;
          w_sda_low_nx = 1'b0;
        end
      endcase
    end
  end

  assign sda      = r_sda_low ? 1'b0 : 1'bz;
  assign rx_byte  = r_rx_byte;
  assign rx_valid = r_rx_valid;
  assign rw       = r_rw;
  assign busy     = r_busy;

endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: bit-banged master, scoreboard queues for written and read bytes.
`timescale 1ns/1ps
module tb_i2c_slave;

`ifdef I2C_SLAVE_FILTER_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 3;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        scl = 1'b1;
  logic        sda_m_low = 1'b0;
  logic [15:0] tx_data = 16'h0000;
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic        rw;
  logic        busy;
  wire         sda_bus;

  assign sda_bus = sda_m_low ? 1'b0 : 1'bz;
  pullup (sda_bus);

  i2c_slave #(.SLAVE_ADDR(7'h48)) dut (
    .clk     (clk),
    .rst     (rst),
    .sda     (sda_bus),
    .scl     (scl),
    .tx_data (tx_data),
    .rx_byte (rx_byte),
    .rx_valid(rx_valid),
    .rw      (rw),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int last_rise = 0;
  int slave_low_cnt = 0;
  logic [7:0] exp_rx[$];
  logic [7:0] exp_rd[$];
  logic [7:0] got_rd[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Written-byte monitor
  always @(negedge clk) begin
    if (!rst && rx_valid) begin
      if (exp_rx.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL rx_unexpected: got 0x%0h expected no rx_valid", rx_byte);
      end else begin
        chk("rx_byte", int'(rx_byte), int'(exp_rx.pop_front()));
        chk("rx_latency", cyc - last_rise, LAT);
      end
    end
  end

  // Read-byte monitor
  always @(negedge clk) begin
    if (got_rd.size() > 0) begin
      logic [7:0] g;
      g = got_rd.pop_front();
      if (exp_rd.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL rd_unexpected: got 0x%0h expected nothing", g);
      end else begin
        chk("rd_byte", int'(g), int'(exp_rd.pop_front()));
      end
    end
  end

  always @(negedge clk) if (sda_bus === 1'b0 && !sda_m_low) slave_low_cnt++;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Starts and ends with scl low (except the first call from idle, which raises scl anyway)
  task automatic bit_xfer(input logic b, output logic rd);
    wait_clks(4);
    sda_m_low = ~b;
    wait_clks(4);
    scl = 1'b1;
    last_rise = cyc;
    wait_clks(4);
    rd = (sda_bus === 1'b0) ? 1'b0 : 1'b1;
    wait_clks(4);
    scl = 1'b0;
  endtask

  task automatic m_start();
    wait_clks(4);
    sda_m_low = 1'b0;
    wait_clks(4);
    scl = 1'b1;
    wait_clks(8);
    sda_m_low = 1'b1;
    wait_clks(8);
    scl = 1'b0;
  endtask

  task automatic m_stop();
    wait_clks(4);
    sda_m_low = 1'b1;
    wait_clks(4);
    scl = 1'b1;
    wait_clks(8);
    sda_m_low = 1'b0;
    wait_clks(8);
  endtask

  task automatic wr_byte(input logic [7:0] v, output logic acked);
    logic r;
    for (int i = 7; i >= 0; i--) bit_xfer(v[i], r);
    bit_xfer(1'b1, r);
    acked = ~r;
  endtask

  task automatic rd_byte(input logic send_ack);
    logic [7:0] v;
    logic r;
    for (int i = 7; i >= 0; i--) begin
      bit_xfer(1'b1, r);
      v[i] = r;
    end
    bit_xfer(~send_ack, r);
    got_rd.push_back(v);
  endtask

  logic a;
  int   low_before;

  initial begin
    wait_clks(5);
    chk("reset_sda", int'(sda_bus), 1);
    chk("reset_busy", int'(busy), 0);
    chk("reset_rx_valid", int'(rx_valid), 0);
    chk("reset_rw", int'(rw), 0);
    chk("reset_rx_byte", int'(rx_byte), 0);
    rst = 1'b0;
    wait_clks(10);

    // Write 0xA5 to 0x48
    m_start();
    wr_byte(8'h90, a);
    chk("w1_addr_ack", int'(a), 1);
    chk("w1_busy_after_match", int'(busy), 1);
    exp_rx.push_back(8'hA5);
    wr_byte(8'hA5, a);
    chk("w1_data_ack", int'(a), 1);
    chk("w1_rw", int'(rw), 0);
    m_stop();
    chk("w1_busy_after_stop", int'(busy), 0);

    // Wrong address 0x49
    low_before = slave_low_cnt;
    m_start();
    wr_byte(8'h92, a);
    chk("w2_addr_nack", int'(a), 0);
    chk("w2_busy", int'(busy), 0);
    wr_byte(8'hFF, a);
    chk("w2_data_nack", int'(a), 0);
    m_stop();
    chk("w2_never_driven", slave_low_cnt - low_before, 0);
    chk("w2_busy_after_stop", int'(busy), 0);

    // General call is not recognised
    low_before = slave_low_cnt;
    m_start();
    wr_byte(8'h00, a);
    chk("gc_nack", int'(a), 0);
    m_stop();
    chk("gc_never_driven", slave_low_cnt - low_before, 0);

    // Read 0xBEEF: ACK byte 1, NACK byte 2
    tx_data = 16'hBEEF;
    m_start();
    wr_byte(8'h91, a);
    chk("r1_addr_ack", int'(a), 1);
    chk("r1_rw", int'(rw), 1);
    exp_rd.push_back(8'hBE);
    exp_rd.push_back(8'hEF);
    rd_byte(1'b1);
    rd_byte(1'b0);
    wait_clks(2);
    chk("r1_sda_released_after_nack", int'(sda_bus), 1);
    chk("r1_busy_after_nack", int'(busy), 0);
    m_stop();

    // Write two bytes, Sr, read three bytes
    tx_data = 16'h0102;
    m_start();
    wr_byte(8'h90, a);
    chk("w3_addr_ack", int'(a), 1);
    exp_rx.push_back(8'h12);
    wr_byte(8'h12, a);
    chk("w3_d0_ack", int'(a), 1);
    exp_rx.push_back(8'h34);
    wr_byte(8'h34, a);
    chk("w3_d1_ack", int'(a), 1);
    m_start();
    wr_byte(8'h91, a);
    chk("r3_addr_ack", int'(a), 1);
    exp_rd.push_back(8'h01);
    exp_rd.push_back(8'h02);
    exp_rd.push_back(8'hFF);
    rd_byte(1'b1);
    rd_byte(1'b1);
    rd_byte(1'b0);
    m_stop();
    chk("r3_busy_after_stop", int'(busy), 0);

    // Reset while the slave drives a 0 data bit
    tx_data = 16'h0000;
    m_start();
    wr_byte(8'h91, a);
    chk("rst_addr_ack", int'(a), 1);
    wait_clks(6);
    chk("rst_pre_sda_low", int'(sda_bus), 0);
    rst = 1'b1;
    wait_clks(1);
    chk("rst_sda_released", int'(sda_bus), 1);
    chk("rst_busy", int'(busy), 0);
    wait_clks(1);
    rst = 1'b0;
    wait_clks(4);
    m_start();
    wr_byte(8'h90, a);
    chk("post_rst_addr_ack", int'(a), 1);
    exp_rx.push_back(8'h5A);
    wr_byte(8'h5A, a);
    chk("post_rst_data_ack", int'(a), 1);
    m_stop();
    chk("post_rst_busy", int'(busy), 0);

`ifdef I2C_SLAVE_FILTER_EN
    // 1-clk sda glitch while scl high must not start a transfer
    low_before = slave_low_cnt;
    wait_clks(10);
    sda_m_low = 1'b1;
    wait_clks(1);
    sda_m_low = 1'b0;
    wait_clks(10);
    scl = 1'b0;
    wr_byte(8'h90, a);
    chk("glitch_no_ack", int'(a), 0);
    chk("glitch_busy", int'(busy), 0);
    m_stop();
    chk("glitch_never_driven", slave_low_cnt - low_before, 0);
`endif

    wait_clks(10);
    chk("rx_queue_drained", exp_rx.size(), 0);
    chk("rd_queue_drained", exp_rd.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
